// File: rtl/conv3_window_gen.sv
// conv3_window_gen: turns a raster-order pixel stream into 3x3 windows
// (stride 1, no padding) for the conv3 filters of one channel.
//
// Handshake: pixel_valid qualifies pixel_in and there is no ready; every
// cycle with pixel_valid=1 is an accepted beat. valid_out is a one-cycle
// pulse per window with no ready either, because the filters take a
// window every clock. data_out, out_row and out_col only change together
// with a valid_out pulse (or reset) and hold their values in between.
module conv3_window_gen #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        pixel_in,
  input  logic                     pixel_valid,
  output logic [DATA_W-1:0]        data_out [0:8],
  output logic                     valid_out,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;

  // lb1 holds the previous row, lb0 the row before it; index IMG_W-1 is the tail
  logic [DATA_W-1:0]  lb0 [0:IMG_W-1];
  logic [DATA_W-1:0]  lb1 [0:IMG_W-1];

  // Window registers, row-major like data_out; index 2/5/8 is the newest column
  logic [DATA_W-1:0]  win      [0:8];
  logic [DATA_W-1:0]  win_next [0:8];

  logic               last_px;
  logic               fire;

  assign last_px = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  // The beat completing a window whose bottom-right pixel is (row, col)
  assign fire    = pixel_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // Next window contents: shift every row left, new right column from the line-buffer tails
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_next[3*r]     = win[3*r + 1];
      win_next[3*r + 1] = win[3*r + 2];
    end
    win_next[2] = lb0[IMG_W-1];
    win_next[5] = lb1[IMG_W-1];
    win_next[8] = pixel_in;
  end

  // Line buffers and window registers shift on accepted beats; contents need no reset
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb1[0] <= pixel_in;
      lb0[0] <= lb1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        lb1[i] <= lb1[i-1];
        lb0[i] <= lb0[i-1];
      end
      for (int i = 0; i < 9; i++) begin
        win[i] <= win_next[i];
      end
    end
  end

  // Frame FSM, raster counters and registered window outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      col        <= '0;
      row        <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      for (int i = 0; i < 9; i++) begin
        data_out[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (pixel_valid) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (pixel_valid && last_px) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // A beat here is pixel (0,0) of the next frame, so go straight back to RUN
          if (pixel_valid) begin
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (pixel_valid) begin
        if (last_px) begin
          col <= '0;
          row <= '0;
        end else if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      valid_out  <= fire;
      frame_done <= pixel_valid && last_px;
      if (fire) begin
        out_row <= row - ROW_W'(2);
        out_col <= col - COL_W'(2);
        for (int i = 0; i < 9; i++) begin
          data_out[i] <= win_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3_window_gen.sv
// Bench for conv3_window_gen: raster frames with and without input gaps,
// back-to-back frames and mid-frame reset, scored against a frame-array model.
module tb_conv3_window_gen;

  localparam int DW   = 32;
  localparam int IW   = 14;
  localparam int IH   = 14;
  localparam int NPIX = IW * IH;
  localparam int WW   = 9 * DW;
  localparam int EW   = WW + 4 + 4 + 1;
  localparam int CW   = 300;

  logic            clk;
  logic            rst_n;
  logic [DW-1:0]   pixel_in;
  logic            pixel_valid;
  logic [DW-1:0]   data_out [0:8];
  logic            valid_out;
  logic [3:0]      out_row;
  logic [3:0]      out_col;
  logic            frame_done;
  logic            busy;

  conv3_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .out_row     (out_row),
    .out_col     (out_col),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q [$];
  logic [DW-1:0] img [0:NPIX-1];
  int            p;
  bit            m_busy;
  bit            m_in_done;
  logic [WW-1:0] last_win;
  int            n_valid;
  int            n_done;
  logic [WW-1:0] first_win;
  logic [WW-1:0] second_win;
  logic [WW-1:0] final_win;
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack_out();
    logic [WW-1:0] v;
    for (int i = 0; i < 9; i++) v[WW-1-i*DW -: DW] = data_out[i];
    return v;
  endfunction

  // Window whose top-left pixel carries raw value b (pixel value = raster index)
  function automatic logic [WW-1:0] win_at(input int b);
    logic [WW-1:0] v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[WW-1-(i*3+j)*DW -: DW] = DW'(b + i*IW + j);
    return v;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    p         = 0;
    m_busy    = 1'b0;
    m_in_done = 1'b0;
    last_win  = '0;
  endfunction

  // driver: one cycle, optionally presenting a pixel; checks the cycle's outputs
  task automatic beat(input bit v, input logic [DW-1:0] val);
    logic [EW-1:0] e;
    logic [WW-1:0] ew;
    bit            ev;
    int            r;
    int            c;
    ev          = 1'b0;
    pixel_valid = v;
    pixel_in    = v ? val : DW'($urandom);
    if (v) begin
      img[p] = val;
      r = p / IW;
      c = p % IW;
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ew[WW-1-(i*3+j)*DW -: DW] = img[(r-2+i)*IW + (c-2+j)];
        e = {ew, 4'(r-2), 4'(c-2), (p == NPIX-1)};
        exp_q.push_back(e);
        ev = 1'b1;
      end
      m_busy    = 1'b1;
      m_in_done = (p == NPIX-1);
      p         = (p + 1) % NPIX;
    end else if (m_in_done) begin
      m_busy    = 1'b0;
      m_in_done = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    pixel_valid = 1'b0;
    check("valid_out", CW'(valid_out), CW'(ev));
    check("busy", CW'(busy), CW'(m_busy));
    if (valid_out) begin
      n_valid++;
      if (n_valid == 1)   first_win  = pack_out();
      if (n_valid == 145) second_win = pack_out();
      if (frame_done) begin
        n_done++;
        final_win = pack_out();
      end
    end
    if (ev && exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      last_win = e[EW-1 -: WW];
      check("out_row", CW'(out_row), CW'(e[8:5]));
      check("out_col", CW'(out_col), CW'(e[4:1]));
      check("frame_done", CW'(frame_done), CW'(e[0]));
    end else begin
      check("frame_done_idle", CW'(frame_done), CW'(0));
    end
    check("data_out", CW'(pack_out()), CW'(last_win));
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any clock edge
  task automatic apply_reset();
    @(negedge clk);
    pixel_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", CW'(valid_out), CW'(0));
    check("rst_done", CW'(frame_done), CW'(0));
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_row_col", CW'({out_row, out_col}), CW'(0));
    check("rst_data", CW'(pack_out()), CW'(0));
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input int base, input int gap_pct, input bit rnd_data);
    for (int k = 0; k < NPIX; k++) begin
      while ($urandom_range(99, 0) < gap_pct) beat(1'b0, '0);
      beat(1'b1, rnd_data ? DW'($urandom) : DW'(base + k));
    end
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    model_clear();
    apply_reset();

    // continuous frame k=0..195
    n_valid = 0; n_done = 0;
    run_frame(0, 0, 1'b0);
    beat(1'b0, '0);
    beat(1'b0, '0);
    check("f1_windows", CW'(n_valid), CW'(144));
    check("f1_done_cnt", CW'(n_done), CW'(1));
    check("f1_first_win", CW'(first_win), CW'(win_at(0)));
    check("f1_last_win", CW'(final_win), CW'(win_at(165)));

    // same frame with ~50% input gaps
    n_valid = 0; n_done = 0;
    run_frame(0, 50, 1'b0);
    repeat (3) beat(1'b0, '0);
    check("gap_windows", CW'(n_valid), CW'(144));
    check("gap_done_cnt", CW'(n_done), CW'(1));
    check("gap_first_win", CW'(first_win), CW'(win_at(0)));
    check("gap_last_win", CW'(final_win), CW'(win_at(165)));

    // back-to-back frames, k continues 196..391 through the DONE cycle
    n_valid = 0; n_done = 0;
    for (int k = 0; k < 2*NPIX; k++) beat(1'b1, DW'(k));
    beat(1'b0, '0);
    beat(1'b0, '0);
    check("b2b_windows", CW'(n_valid), CW'(288));
    check("b2b_done_cnt", CW'(n_done), CW'(2));
    check("b2b_second_win", CW'(second_win), CW'(win_at(196)));

    // random pixel data with gaps
    n_valid = 0; n_done = 0;
    run_frame(0, 30, 1'b1);
    beat(1'b0, '0);
    check("rnd_windows", CW'(n_valid), CW'(144));

    // reset after 100 pixels, then restart at k=0
    for (int k = 0; k < 100; k++) beat(1'b1, DW'(1000 + k));
    apply_reset();
    n_valid = 0; n_done = 0;
    run_frame(0, 0, 1'b0);
    beat(1'b0, '0);
    check("rst_windows", CW'(n_valid), CW'(144));
    check("rst_first_win", CW'(first_win), CW'(win_at(0)));
    check("rst_done_cnt", CW'(n_done), CW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
